// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the writeback entry record.
package mips_pkg;

    localparam int REG_W    = 32;
    localparam int NUM_REGS = 32;
    localparam int SEL_W    = 5;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [REG_W-1:0] data;
    } wb_entry_t;

    // Next pointer value, wrapping modulo a power-of-two depth.
    function automatic logic [7:0] ptr_next(input logic [7:0] p, input int depth);
        return (p + 8'd1) & 8'(depth - 1);
    endfunction

endpackage

// File: rtl/wb_bypass_match.sv
// Youngest-match search over pending writeback entries, for decode operand bypass.
// Only instantiated when WB_BYPASS_EN is defined.
module wb_bypass_match
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = mips_pkg::REG_W,
    parameter int SEL_W = mips_pkg::SEL_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [SEL_W-1:0] ent_sel  [DEPTH],
    input  logic [WIDTH-1:0] ent_data [DEPTH],
    input  logic [DEPTH-1:0] ent_vld,
    input  logic [PTR_W-1:0] rd_ptr,
    input  logic [SEL_W-1:0] byp_reg,
    output logic             byp_hit,
    output logic [WIDTH-1:0] byp_data
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest from rd_ptr; later matches overwrite earlier ones,
    // so the entry closest to wr_ptr wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        idx      = '0;
        if (byp_reg != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_ptr + PTR_W'(k);
                if (ent_vld[idx] && ent_sel[idx] == byp_reg) begin
                    byp_hit  = 1'b1;
                    byp_data = ent_data[idx];
                end
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Writeback FIFO feeding the register-file write port, one retire per cycle.
// Optional decode bypass lookup enabled by defining WB_BYPASS_EN.
module wb_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = mips_pkg::REG_W,
    parameter int SEL_W = mips_pkg::SEL_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_reg,
    input  logic [WIDTH-1:0] in_data,
    input  logic             rf_stall,
    output logic             rf_write,
    output logic [SEL_W-1:0] rf_write_reg,
    output logic [WIDTH-1:0] rf_write_data,
    output logic [CNT_W-1:0] count,
`ifdef WB_BYPASS_EN
    input  logic [SEL_W-1:0] byp_reg,
    output logic             byp_hit,
    output logic [WIDTH-1:0] byp_data,
`endif
    output logic             empty
);

    logic [SEL_W-1:0] sel_q  [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop;

    assign empty    = (count == '0);
    assign in_ready = (count != CNT_W'(DEPTH));
    // r0 writes complete the handshake but are discarded.
    assign push     = in_valid && in_ready && (in_reg != '0);
    assign pop      = rf_write;

    assign rf_write      = !empty && !rf_stall;
    assign rf_write_reg  = empty ? '0 : sel_q[rd_ptr];
    assign rf_write_data = empty ? '0 : data_q[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr        <= wr_ptr + 1'b1;
                vld_q[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                vld_q[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: valid bits and count gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            sel_q[wr_ptr]  <= in_reg;
            data_q[wr_ptr] <= in_data;
        end
    end

`ifdef WB_BYPASS_EN
    wb_bypass_match #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_byp (
        .ent_sel  (sel_q),
        .ent_data (data_q),
        .ent_vld  (vld_q),
        .rd_ptr   (rd_ptr),
        .byp_reg  (byp_reg),
        .byp_hit  (byp_hit),
        .byp_data (byp_data)
    );
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: scoreboard on the write port plus a vector table.
module tb_wb_queue;
    import mips_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int SW    = 5;
    localparam int CW    = 3;

    logic             clk, rst;
    logic             in_valid, in_ready;
    logic [SW-1:0]    in_reg;
    logic [WIDTH-1:0] in_data;
    logic             rf_stall, rf_write;
    logic [SW-1:0]    rf_write_reg;
    logic [WIDTH-1:0] rf_write_data;
    logic [CW-1:0]    count;
    logic             empty;
`ifdef WB_BYPASS_EN
    logic [SW-1:0]    byp_reg;
    logic             byp_hit;
    logic [WIDTH-1:0] byp_data;
`endif

    wb_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SEL_W(SW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_reg        (in_reg),
        .in_data       (in_data),
        .rf_stall      (rf_stall),
        .rf_write      (rf_write),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .count         (count),
`ifdef WB_BYPASS_EN
        .byp_reg       (byp_reg),
        .byp_hit       (byp_hit),
        .byp_data      (byp_data),
`endif
        .empty         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0]    r;
        logic [WIDTH-1:0] d;
    } exp_t;

    typedef struct {
        logic          v;
        logic [SW-1:0] r;
        logic [31:0]   d;
        logic          st;
        logic [CW-1:0] exp_cnt;
        logic          exp_rdy;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: settle, score the write port and any accepted push, then advance.
    task automatic cyc();
        exp_t e;
        #1;
        if (rf_write) begin
            chk("write_with_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wb_reg", 64'(rf_write_reg), 64'(e.r));
                chk("wb_data", 64'(rf_write_data), 64'(e.d));
            end
        end
        if (in_valid && in_ready && in_reg != '0) begin
            e.r = in_reg;
            e.d = in_data;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [SW-1:0] r, input logic [31:0] d);
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0; rf_stall = 1'b0;
`ifdef WB_BYPASS_EN
        byp_reg = '0;
`endif
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_rf_write", 64'(rf_write), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single push: visible only after the edge, gone one cycle later.
        in_valid = 1'b1; in_reg = 5'd5; in_data = 32'hDEADBEEF;
        #1;
        chk("no_passthru", 64'(rf_write), 64'd0);
        cyc();
        in_valid = 1'b0;
        chk("lat_write", 64'(rf_write), 64'd1);
        chk("lat_reg", 64'(rf_write_reg), 64'd5);
        chk("lat_data", 64'(rf_write_data), 64'hDEADBEEF);
        cyc();
        chk("lat_empty", 64'(empty), 64'd1);
        chk("lat_rf_write", 64'(rf_write), 64'd0);

        // Fill under stall, reject when full, then drain in order.
        vecs[0] = '{1'b1, 5'd1, 32'hA1, 1'b1, 3'd1, 1'b1};
        vecs[1] = '{1'b1, 5'd2, 32'hA2, 1'b1, 3'd2, 1'b1};
        vecs[2] = '{1'b1, 5'd3, 32'hA3, 1'b1, 3'd3, 1'b1};
        vecs[3] = '{1'b1, 5'd4, 32'hA4, 1'b1, 3'd4, 1'b0};
        vecs[4] = '{1'b1, 5'd9, 32'hA9, 1'b1, 3'd4, 1'b0};
        vecs[5] = '{1'b0, 5'd0, 32'h0,  1'b0, 3'd3, 1'b1};
        vecs[6] = '{1'b0, 5'd0, 32'h0,  1'b0, 3'd2, 1'b1};
        vecs[7] = '{1'b0, 5'd0, 32'h0,  1'b1, 3'd2, 1'b1};
        vecs[8] = '{1'b0, 5'd0, 32'h0,  1'b0, 3'd1, 1'b1};
        vecs[9] = '{1'b0, 5'd0, 32'h0,  1'b0, 3'd0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            in_valid = vecs[i].v; in_reg = vecs[i].r; in_data = vecs[i].d;
            rf_stall = vecs[i].st;
            if (i >= 5 && !vecs[i].st) begin
                #1;
                chk("drain_order", 64'(rf_write_reg), 64'(i - 4 - (i > 7 ? 1 : 0)));
            end
            cyc();
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
        end
        in_valid = 1'b0; rf_stall = 1'b0;

        // r0 destination: accepted, never stored.
        in_valid = 1'b1; in_reg = 5'd0; in_data = 32'h1234;
        #1;
        chk("r0_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        chk("r0_count", 64'(count), 64'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("r0_no_write", 64'(rf_write), 64'd0);
            cyc();
        end

        // Steady push+pop at count 2.
        rf_stall = 1'b1;
        push_one(5'd1, 32'hB001);
        push_one(5'd2, 32'hB002);
        rf_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_reg = 5'(3 + i); in_data = 32'hC000 + 32'(i);
            cyc();
            chk("pp_count", 64'(count), 64'd2);
        end
        in_valid = 1'b0;
        cyc(); cyc();
        chk("pp_empty", 64'(empty), 64'd1);

`ifdef WB_BYPASS_EN
        rf_stall = 1'b1;
        push_one(5'd7, 32'h11);
        push_one(5'd7, 32'h22);
        byp_reg = 5'd7;
        #1;
        chk("byp_hit", 64'(byp_hit), 64'd1);
        chk("byp_data", 64'(byp_data), 64'h22);
        byp_reg = 5'd0;
        #1;
        chk("byp_r0", 64'(byp_hit), 64'd0);
        byp_reg = 5'd7;
        rf_stall = 1'b0;
        cyc(); cyc();
        chk("byp_retired", 64'(byp_hit), 64'd0);
        byp_reg = 5'd0;
`endif

        // Reset mid-drain drops everything without waiting for a clock.
        rf_stall = 1'b1;
        push_one(5'd10, 32'hE10);
        push_one(5'd11, 32'hE11);
        push_one(5'd12, 32'hE12);
        rf_stall = 1'b0;
        #1;
        chk("pre_rst_count", 64'(count), 64'd3);
        chk("pre_rst_write", 64'(rf_write), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_empty", 64'(empty), 64'd1);
        chk("mid_rst_write", 64'(rf_write), 64'd0);
        sb.delete();
        #1 rst = 1'b0;
        @(posedge clk); #1;
        push_one(5'd6, 32'h600D);
        #1;
        chk("post_rst_reg", 64'(rf_write_reg), 64'd6);
        cyc();
        chk("post_rst_empty", 64'(empty), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
